// File: rtl/tinyloader.sv
// Byte-serial program loader: writes 16-bit words into the CPU program RAM, then releases and starts the CPU.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tinyloader #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d,
  output logic          cpu_hold,
  output logic          run,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_AH,
    S_AL,
    S_CH,
    S_CL,
    S_DH,
    S_DL,
`ifdef LOADER_CHECKSUM_EN
    S_CS,
`endif
    S_GO
  } state_t;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CS;
`else
  localparam state_t S_POST = S_GO;
`endif

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    hi_q, hi_d;
  logic          we_q, we_d;
  logic [AW-1:0] maddr_q, maddr_d;
  logic [DW-1:0] md_q, md_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          xfer;
  logic [AW-1:0] field_w;
`ifdef LOADER_CHECKSUM_EN
  logic          err_q, err_d;
  logic [7:0]    csum_q, csum_d;
`endif

  assign in_ready = (state_q != S_GO);
  assign xfer     = in_valid && in_ready;
  // ADDR and CNT keep only the low AW bits of the 16-bit field.
  assign field_w  = {hi_q[AW-9:0], in_data};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    md_d    = md_q;
    hold_d  = hold_q;
    done_d  = done_q;
`ifdef LOADER_CHECKSUM_EN
    err_d   = err_q;
    csum_d  = xfer ? (csum_q ^ in_data) : csum_q;
`endif
    case (state_q)
      S_AH: if (xfer) begin
        hi_d    = in_data;
        hold_d  = 1'b1;
        done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        err_d   = 1'b0;
        csum_d  = in_data;
`endif
        state_d = S_AL;
      end
      S_AL: if (xfer) begin
        addr_d  = field_w;
        state_d = S_CH;
      end
      S_CH: if (xfer) begin
        hi_d    = in_data;
        state_d = S_CL;
      end
      S_CL: if (xfer) begin
        cnt_d   = field_w;
        state_d = (field_w == '0) ? S_POST : S_DH;
      end
      S_DH: if (xfer) begin
        hi_d    = in_data;
        state_d = S_DL;
      end
      S_DL: if (xfer) begin
        we_d    = 1'b1;
        maddr_d = addr_q;
        md_d    = {hi_q, in_data};
        addr_d  = addr_q + 1'b1;
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == AW'(1)) ? S_POST : S_DH;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CS: if (xfer) begin
        if (csum_q == in_data) begin
          state_d = S_GO;
        end else begin
          err_d   = 1'b1;
          state_d = S_AH;
        end
      end
`endif
      S_GO: begin
        done_d  = 1'b1;
        state_d = S_AH;
      end
      default: state_d = S_AH;
    endcase
    if (state_d == S_GO) hold_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_AH;
      addr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      md_q    <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      err_q   <= 1'b0;
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      md_q    <= md_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
      err_q   <= err_d;
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = maddr_q;
  assign mem_d    = md_q;
  assign cpu_hold = hold_q;
  assign run      = (state_q == S_GO);
  assign busy     = (state_q != S_AH);
  assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_tinyloader.sv
// Directed self-checking bench for tinyloader; follows LOADER_CHECKSUM_EN to decide whether frames carry a CSUM byte.
`timescale 1ns/1ps
module tb_tinyloader;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, cpu_hold, run, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d;

  int unsigned n_tests = 0, n_fail = 0;
  int unsigned n_writes = 0, n_runs = 0, n_rdy_bad = 0, exp_runs = 0;
  logic [15:0] wv [4];

  always #5 clk = ~clk;

  tinyloader #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_d(mem_d), .cpu_hold(cpu_hold),
    .run(run), .busy(busy), .done(done), .err(err)
  );

  // in_ready must be low exactly in the S_GO cycle, which is the run cycle
  always @(negedge clk) if (reset) begin
    if (mem_we) n_writes++;
    if (run) n_runs++;
    if (in_ready == run) n_rdy_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_cpu_hold"}, cpu_hold, 1);
    chk({tag, "_mem_we"},   mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_d"},    mem_d, 0);
    chk({tag, "_run"},      run, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_done"},     done, 0);
    chk({tag, "_err"},      err, 0);
  endtask

  // Returns #1 after the accepting edge, with in_valid already dropped.
  task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
    int unsigned gap;
    bit ok;
    gap = (maxgap == 0) ? 0 : $urandom_range(maxgap, 0);
    ok  = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input logic [15:0] a, input logic [15:0] c, input logic [15:0] w [4],
                            input int unsigned maxgap, input bit bad);
    logic [7:0]  cs;
    logic [11:0] ad;
    int unsigned n, w0, r0;
    bit          good;
    n  = int'(c[11:0]);
    ad = a[11:0];
    w0 = n_writes;
    r0 = n_runs;
    good = 1'b1;
    cs = a[15:8] ^ a[7:0] ^ c[15:8] ^ c[7:0];
    send_byte(a[15:8], maxgap);
    chk("ah_busy", busy, 1);
    chk("ah_hold", cpu_hold, 1);
    chk("ah_done_clr", done, 0);
    chk("ah_err_clr", err, 0);
    send_byte(a[7:0], maxgap);
    send_byte(c[15:8], maxgap);
    send_byte(c[7:0], maxgap);
    for (int unsigned i = 0; i < n; i++) begin
      send_byte(w[i][15:8], maxgap);
      send_byte(w[i][7:0], maxgap);
      cs = cs ^ w[i][15:8] ^ w[i][7:0];
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, ad);
      chk("wr_data", mem_d, w[i]);
      ad = ad + 1'b1;
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad ? 8'h00 : cs, maxgap);
    good = !bad;
`endif
    if (good) begin
      chk("go_run", run, 1);
      chk("go_hold", cpu_hold, 0);
      chk("go_ready", in_ready, 0);
      chk("go_busy", busy, 1);
      exp_runs++;
    end else begin
      chk("bad_run", run, 0);
      chk("bad_err", err, 1);
      chk("bad_hold", cpu_hold, 1);
      chk("bad_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    chk("post_run", run, 0);
    chk("post_done", done, good);
    chk("post_busy", busy, 0);
    chk("post_ready", in_ready, 1);
    chk("post_hold", cpu_hold, !good);
    chk("frame_writes", n_writes - w0, n);
    chk("frame_runs", n_runs - r0, good);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk_reset_vals("rst0");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    wv = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000};
    load_frame(16'h0010, 16'h0002, wv, 0, 1'b0);

    wv = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
    load_frame(16'h0FFF, 16'h0002, wv, 0, 1'b0);

    // upper nibble of ADDR and CNT ignored: address 0x005, one word
    wv = '{16'h5A5A, 16'h0000, 16'h0000, 16'h0000};
    load_frame(16'hF005, 16'hF001, wv, 0, 1'b0);

    load_frame(16'h0000, 16'h0000, wv, 0, 1'b0);

    wv = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000};
    load_frame(16'h0010, 16'h0002, wv, 5, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    load_frame(16'h0010, 16'h0002, wv, 0, 1'b1);
    load_frame(16'h0010, 16'h0002, wv, 2, 1'b0);
`endif

    @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_vals("rst_idle");
    @(negedge clk);
    reset = 1'b1;

    send_byte(8'h00, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    chk("mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_reset_vals("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    chk("ready_only_in_go", n_rdy_bad, 0);
    chk("run_total", n_runs, exp_runs);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
